// File: rtl/text_buffer_ctrl.sv
`timescale 1ns/1ps
// Character-cell text buffer: cursor-driven writes from a command port, an independent
// registered read port for the display, and a self-clearing sequence after reset or clear.
module text_buffer_ctrl #(
    parameter int          COLS  = 32,
    parameter int          ROWS  = 16,
    parameter logic [4:0]  BLANK = 5'd31,
    localparam int         CW    = $clog2(COLS),
    localparam int         RW    = $clog2(ROWS),
    localparam int         AW    = CW + RW
) (
    input  logic          pixel_clk_in,
    input  logic          rst_in,
    input  logic [1:0]    cmd_in,
    input  logic [4:0]    char_in,
    input  logic          valid_in,
    output logic          ready_out,
    input  logic [AW-1:0] rd_addr_in,
    output logic [4:0]    rd_data_out,
    output logic [CW-1:0] cursor_col_out,
    output logic [RW-1:0] cursor_row_out,
    output logic          full_out,
    output logic          busy_out
);

    localparam int CELLS = COLS * ROWS;
    localparam logic [AW:0]   IDX_FULL  = (AW+1)'(CELLS);
    localparam logic [AW:0]   IDX_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   ROW_STEP  = (AW+1)'(COLS);
    localparam logic [AW-1:0] ADDR_LAST = AW'(CELLS - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    typedef enum logic [1:0] {CMD_CHAR = 2'd0, CMD_BS = 2'd1, CMD_NL = 2'd2, CMD_CLR = 2'd3} cmd_t;
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t        state;
    logic [AW:0]   idx;
    logic [AW:0]   idx_nxt;
    logic [AW:0]   idx_dec;
    logic [AW-1:0] clr_addr;
    logic          accept;
    logic          we;
    logic [AW-1:0] waddr;
    logic [4:0]    wdata;
    logic [4:0]    mem [CELLS];

    assign accept   = valid_in && ready_out;
    assign idx_dec  = idx - IDX_ONE;
    assign full_out = (idx == IDX_FULL);

    // The full position has no real cell; report it as the last one.
    assign cursor_col_out = full_out ? {CW{1'b1}} : idx[CW-1:0];
    assign cursor_row_out = full_out ? {RW{1'b1}} : idx[AW-1:CW];

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        we      = 1'b0;
        waddr   = clr_addr;
        wdata   = BLANK;
        idx_nxt = idx;
        if (state == S_CLEAR) begin
            we = 1'b1;
        end else if (accept) begin
            case (cmd_t'(cmd_in))
                CMD_CHAR: if (!full_out) begin
                    we      = 1'b1;
                    waddr   = idx[AW-1:0];
                    wdata   = char_in;
                    idx_nxt = idx + IDX_ONE;
                end
                CMD_BS: if (idx != '0) begin
                    we      = 1'b1;
                    waddr   = idx_dec[AW-1:0];
                    idx_nxt = idx_dec;
                end
                CMD_NL:  idx_nxt = full_out ? idx : ({1'b0, idx[AW-1:CW], {CW{1'b0}}} + ROW_STEP);
                CMD_CLR: idx_nxt = '0;
                default: idx_nxt = idx;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state     <= S_CLEAR;
            ready_out <= 1'b0;
            busy_out  <= 1'b1;
            clr_addr  <= '0;
            idx       <= '0;
        end else begin
            idx <= idx_nxt;
            case (state)
                S_IDLE: if (accept && cmd_t'(cmd_in) == CMD_CLR) begin
                    state     <= S_CLEAR;
                    ready_out <= 1'b0;
                    busy_out  <= 1'b1;
                    clr_addr  <= '0;
                end
                S_CLEAR: begin
                    clr_addr <= clr_addr + ADDR_ONE;
                    if (clr_addr == ADDR_LAST) begin
                        state     <= S_IDLE;
                        ready_out <= 1'b1;
                        busy_out  <= 1'b0;
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    // NOTE: the cell array has no reset; the clear sequence that follows reset blanks it.
    // A same-edge read of the cell being written returns the old contents.
    always_ff @(posedge pixel_clk_in) begin
        if (we && !rst_in) mem[waddr] <= wdata;
        rd_data_out <= rst_in ? BLANK : mem[rd_addr_in];
    end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
`timescale 1ns/1ps
// Directed bench for text_buffer_ctrl: a command vector table plus hand-written
// sequences for clear timing, full buffer, read/write collision and reset mid-clear.
module tb_text_buffer_ctrl;

    localparam int BLANK = 31;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic [4:0] ch = 5'd0;
    logic       valid = 1'b0;
    logic [8:0] rd_addr = 9'd0;
    logic       ready;
    logic [4:0] rd_data;
    logic [4:0] col;
    logic [3:0] row;
    logic       full;
    logic       busy;

    int checks = 0;
    int errors = 0;

    text_buffer_ctrl dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst),
        .cmd_in         (cmd),
        .char_in        (ch),
        .valid_in       (valid),
        .ready_out      (ready),
        .rd_addr_in     (rd_addr),
        .rd_data_out    (rd_data),
        .cursor_col_out (col),
        .cursor_row_out (row),
        .full_out       (full),
        .busy_out       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [1:0] c, input logic [4:0] d);
        cmd   = c;
        ch    = d;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    task automatic read_cell(input int addr, output int data);
        rd_addr = 9'(addr);
        tick();
        data = int'(rd_data);
    endtask

    task automatic wait_ready(input string name, input int expected);
        int n = 0;
        while (!ready && n < 2000) begin
            tick();
            n++;
        end
        check(name, n, expected);
    endtask

    typedef struct {
        logic [1:0] c;
        logic [4:0] d;
        int         col;
        int         row;
        int         full;
    } vec_t;

    typedef struct {
        int addr;
        int data;
    } cell_t;

    vec_t  vecs[14];
    cell_t cells[7];

    initial begin
        int d;
        int bad;

        vecs[0]  = '{2'd1, 5'd0,  0,  0, 0};  // backspace at index 0: no-op
        vecs[1]  = '{2'd0, 5'd3,  1,  0, 0};
        vecs[2]  = '{2'd0, 5'd4,  2,  0, 0};
        vecs[3]  = '{2'd2, 5'd0,  0,  1, 0};
        vecs[4]  = '{2'd1, 5'd0, 31,  0, 0};  // col 0 wraps back to col 31
        vecs[5]  = '{2'd0, 5'd5,  0,  1, 0};
        vecs[6]  = '{2'd2, 5'd0,  0,  2, 0};
        vecs[7]  = '{2'd2, 5'd0,  0,  3, 0};
        vecs[8]  = '{2'd0, 5'd10, 1,  3, 0};
        vecs[9]  = '{2'd0, 5'd11, 2,  3, 0};
        vecs[10] = '{2'd0, 5'd12, 3,  3, 0};
        vecs[11] = '{2'd0, 5'd13, 4,  3, 0};
        vecs[12] = '{2'd0, 5'd14, 5,  3, 0};
        vecs[13] = '{2'd2, 5'd0,  0,  4, 0};  // newline from col 5 row 3
        cells[0] = '{0, 3};
        cells[1] = '{1, 4};
        cells[2] = '{2, BLANK};
        cells[3] = '{31, 5};
        cells[4] = '{96, 10};
        cells[5] = '{100, 14};
        cells[6] = '{101, BLANK};

        // Reset and initial clear
        rst = 1'b1;
        tick();
        tick();
        check("reset_ready", int'(ready), 0);
        check("reset_busy", int'(busy), 1);
        check("reset_full", int'(full), 0);
        check("reset_rd_data", int'(rd_data), BLANK);
        rst = 1'b0;
        wait_ready("reset_clear_cycles", 512);
        check("idle_busy", int'(busy), 0);
        read_cell(0, d);   check("blank_cell_0", d, BLANK);
        read_cell(255, d); check("blank_cell_255", d, BLANK);
        read_cell(511, d); check("blank_cell_511", d, BLANK);

        // Command table
        foreach (vecs[i]) begin
            do_cmd(vecs[i].c, vecs[i].d);
            check($sformatf("vec%0d_col", i), int'(col), vecs[i].col);
            check($sformatf("vec%0d_row", i), int'(row), vecs[i].row);
            check($sformatf("vec%0d_full", i), int'(full), vecs[i].full);
        end
        foreach (cells[i]) begin
            read_cell(cells[i].addr, d);
            check($sformatf("table_cell_%0d", cells[i].addr), d, cells[i].data);
        end

        // Clear command, then letters 0..25
        do_cmd(2'd3, 5'd0);
        check("clear_ready_low", int'(ready), 0);
        check("clear_busy_high", int'(busy), 1);
        check("clear_cursor_col", int'(col), 0);
        wait_ready("clear_cmd_cycles", 512);
        for (int i = 0; i < 26; i++) do_cmd(2'd0, 5'(i));
        check("alpha_col", int'(col), 26);
        check("alpha_row", int'(row), 0);
        bad = 0;
        for (int i = 0; i < 26; i++) begin
            read_cell(i, d);
            if (d != i) bad++;
        end
        check("alpha_cells_bad", bad, 0);
        for (int i = 0; i < 6; i++) do_cmd(2'd0, 5'd1);
        check("wrap_col", int'(col), 0);
        check("wrap_row", int'(row), 1);

        // Same-edge write and read of cell 40
        for (int i = 0; i < 8; i++) do_cmd(2'd0, 5'd1);
        check("pre_collide_col", int'(col), 8);
        rd_addr = 9'd40;
        do_cmd(2'd0, 5'd9);
        check("collide_old", int'(rd_data), BLANK);
        tick();
        check("collide_new", int'(rd_data), 9);

        // Fill the whole buffer
        do_cmd(2'd3, 5'd0);
        wait_ready("clear2_cycles", 512);
        for (int i = 0; i < 512; i++) do_cmd(2'd0, 5'd7);
        check("fill_full", int'(full), 1);
        check("fill_col", int'(col), 31);
        check("fill_row", int'(row), 15);
        do_cmd(2'd0, 5'd3);
        check("overflow_full", int'(full), 1);
        read_cell(511, d); check("overflow_cell_511", d, 7);
        do_cmd(2'd1, 5'd0);
        check("bs_from_full", int'(full), 0);
        check("bs_from_full_col", int'(col), 31);
        check("bs_from_full_row", int'(row), 15);
        read_cell(511, d); check("bs_cell_511", d, BLANK);
        read_cell(0, d);   check("fill_cell_0", d, 7);
        do_cmd(2'd2, 5'd0);
        check("nl_row15_full", int'(full), 1);
        do_cmd(2'd2, 5'd0);
        check("nl_when_full", int'(full), 1);
        do_cmd(2'd1, 5'd0);
        check("bs_again_col", int'(col), 31);

        // Clear interrupted by reset at clear cycle 200
        do_cmd(2'd3, 5'd0);
        for (int i = 0; i < 100; i++) tick();
        rd_addr = 9'd50;
        tick();
        check("mid_clear_done_cell", int'(rd_data), BLANK);
        rd_addr = 9'd400;
        tick();
        check("mid_clear_old_cell", int'(rd_data), 7);
        check("mid_clear_ready", int'(ready), 0);
        for (int i = 0; i < 97; i++) tick();
        rst   = 1'b1;
        valid = 1'b1;
        cmd   = 2'd0;
        ch    = 5'd3;
        tick();
        rst   = 1'b0;
        valid = 1'b0;
        check("rst_mid_busy", int'(busy), 1);
        check("rst_mid_rd_data", int'(rd_data), BLANK);
        check("rst_mid_col", int'(col), 0);
        check("rst_mid_row", int'(row), 0);
        wait_ready("rst_mid_clear_cycles", 512);
        check("rst_mid_full", int'(full), 0);
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            read_cell(i, d);
            if (d != BLANK) bad++;
        end
        check("rst_mid_cells_bad", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
